usb_bus_state_ctrl: RTL

USB_BUS_STATE_CTRL -- requirements
Module: usb_bus_state_ctrl

---
 rtl/usb_phy_pkg.sv | 40 ++++
 rtl/usb_sync2.sv | 21 ++
 rtl/usb_bus_state_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/usb_phy_pkg.sv
// Shared USB bus-state definitions: line-state codes, FSM encodings and
// helpers that size the run and dwell counters from the timing parameters.
package usb_phy_pkg;

    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_J   = 2'b01;
    localparam logic [1:0] LINE_K   = 2'b10;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    // Minimum suspend dwell before remote wakeup is allowed, in ATTACH_CYCLES units.
    localparam int DWELL_PER_ATTACH = 2 * 25;

    typedef enum logic [2:0] {
        ST_DETACHED  = 3'd0,
        ST_ATTACH    = 3'd1,
        ST_IDLE      = 3'd2,
        ST_BUS_RESET = 3'd3,
        ST_SUSPEND   = 3'd4,
        ST_RESUME    = 3'd5,
        ST_WAKEUP    = 3'd6
    } bus_state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int reset_cycles, input int suspend_cycles,
                                     input int attach_cycles, input int wakeup_cycles);
        int m;
        m = max_of(max_of(reset_cycles, suspend_cycles), max_of(attach_cycles, wakeup_cycles));
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int dwell_width(input int attach_cycles, input int wakeup_cycles);
        int m;
        m = max_of(attach_cycles * DWELL_PER_ATTACH, max_of(attach_cycles, wakeup_cycles));
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/usb_sync2.sv
// Two-flop synchronizer for one asynchronous bit; clears to 0 on reset.
module usb_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/usb_bus_state_ctrl.sv
// USB device bus-state controller: tracks attach, bus reset, suspend, resume
// and remote wakeup from the synchronized line state and VBUS.
module usb_bus_state_ctrl
    import usb_phy_pkg::*;
#(
    parameter int RESET_CYCLES   = 120,
    parameter int SUSPEND_CYCLES = 144000,
    parameter int ATTACH_CYCLES  = 4800,
    parameter int WAKEUP_CYCLES  = 48000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] usb_line_state,
    input  logic       vbus_valid,
    input  logic       wakeup_req,
    output logic [2:0] bus_state,
    output logic       bus_reset,
    output logic       suspend,
    output logic       resume_pulse,
    output logic       drive_k,
    output logic       wakeup_ack,
    output logic       line_err
);

    localparam int CNT_W        = cnt_width(RESET_CYCLES, SUSPEND_CYCLES, ATTACH_CYCLES, WAKEUP_CYCLES);
    localparam int DWELL_CYCLES = ATTACH_CYCLES * DWELL_PER_ATTACH;
    localparam int DW_W         = dwell_width(ATTACH_CYCLES, WAKEUP_CYCLES);

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SUSPEND_LAST = CNT_W'(SUSPEND_CYCLES - 1);
    // The DETACHED cycle that first sees VBUS counts toward the debounce.
    localparam logic [DW_W-1:0]  ATTACH_LAST  = DW_W'(ATTACH_CYCLES - 2);
    localparam logic [DW_W-1:0]  WAKEUP_LAST  = DW_W'(WAKEUP_CYCLES - 1);
    localparam logic [DW_W-1:0]  DWELL_MIN    = DW_W'(DWELL_CYCLES);

    logic [1:0]       line_s;
    logic [1:0]       line_prev;
    logic             vbus_s;
    bus_state_t       state;
    bus_state_t       next_state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run;
    logic [DW_W-1:0]  dwell_cnt;
    logic             se0_seen;
    logic             state_chg;
    logic             wake_ok;

    usb_sync2 u_sync_line0 (.clk(clk), .rst_n(rst_n), .d(usb_line_state[0]), .q(line_s[0]));
    usb_sync2 u_sync_line1 (.clk(clk), .rst_n(rst_n), .d(usb_line_state[1]), .q(line_s[1]));
    usb_sync2 u_sync_vbus  (.clk(clk), .rst_n(rst_n), .d(vbus_valid),        .q(vbus_s));

    // Run length of the current line state, counting the present cycle as 0.
    assign run       = (line_s != line_prev) ? '0 : run_cnt;
    assign state_chg = (next_state != state);
    assign wake_ok   = wakeup_req && (line_s == LINE_J) && (dwell_cnt >= DWELL_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_DETACHED;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_prev <= LINE_SE0;
            run_cnt   <= '0;
            dwell_cnt <= '0;
            se0_seen  <= 1'b0;
        end else begin
            line_prev <= line_s;
            if (state_chg) begin
                run_cnt   <= '0;
                dwell_cnt <= '0;
                se0_seen  <= 1'b0;
            end else begin
                run_cnt   <= (&run) ? run : run + CNT_W'(1);
                dwell_cnt <= (&dwell_cnt) ? dwell_cnt : dwell_cnt + DW_W'(1);
                if (state == ST_RESUME && line_s == LINE_SE0) begin
                    se0_seen <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_DETACHED: begin
                if (vbus_s) next_state = ST_ATTACH;
            end
            ST_ATTACH: begin
                if (dwell_cnt >= ATTACH_LAST) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (line_s == LINE_SE0 && run == RESET_LAST) begin
                    next_state = ST_BUS_RESET;
                end else if (line_s == LINE_J && run == SUSPEND_LAST) begin
                    next_state = ST_SUSPEND;
                end
            end
            ST_BUS_RESET: begin
                if (line_s != LINE_SE0) next_state = ST_IDLE;
            end
            ST_SUSPEND: begin
                // Host resume (K) outranks a simultaneous wakeup request.
                if (line_s == LINE_K) begin
                    next_state = ST_RESUME;
                end else if (line_s == LINE_SE0 && run == RESET_LAST) begin
                    next_state = ST_BUS_RESET;
                end else if (wake_ok) begin
                    next_state = ST_WAKEUP;
                end
            end
            ST_RESUME: begin
                if (line_s == LINE_SE0 && run == RESET_LAST) begin
                    next_state = ST_BUS_RESET;
                end else if (line_s == LINE_J && se0_seen) begin
                    next_state = ST_IDLE;
                end
            end
            ST_WAKEUP: begin
                if (dwell_cnt == WAKEUP_LAST) next_state = ST_RESUME;
            end
            default: next_state = ST_DETACHED;
        endcase
        if (!vbus_s) next_state = ST_DETACHED;
    end

    always_comb begin
        bus_state    = state;
        bus_reset    = (state == ST_BUS_RESET);
        suspend      = (state == ST_SUSPEND);
        drive_k      = (state == ST_WAKEUP);
        wakeup_ack   = (state == ST_SUSPEND) && (next_state == ST_WAKEUP);
        resume_pulse = (state == ST_RESUME) && (next_state == ST_IDLE);
        line_err     = (line_s == LINE_SE1) && (line_prev != LINE_SE1);
    end

endmodule
